// File: rtl/debug_uart_tx.sv
// Debug-word UART transmitter: start bit, WIDTH data bits LSB first, optional even
// parity (define DEBUG_UART_TX_PARITY_EN), one stop bit. o_tx is driven from a register.
module debug_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done,
  output logic [2:0]       state_dbg
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(WIDTH + 1);

  // State encoding is visible on state_dbg; ST_IDLE is 0.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic               accept;
  logic               baud_last;
`ifdef DEBUG_UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  // Handshake: a word is taken when i_valid and o_ready are both high at a rising
  // clk edge; o_ready is high only in IDLE, and i_valid outside IDLE is dropped.
  assign accept    = i_valid && (state_q == ST_IDLE);
  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef DEBUG_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef DEBUG_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    tx_d     = 1'b1;
`ifdef DEBUG_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d  = i_data;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = ST_START;
`ifdef DEBUG_UART_TX_PARITY_EN
          parity_d = ^i_data;
`endif
        end
      end

      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(WIDTH - 1)) begin
            bit_d   = '0;
`ifdef DEBUG_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

`ifdef DEBUG_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif

      ST_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // The line level is a function of the state being entered, so the pin is
    // registered yet the start bit still appears the cycle after accept.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
`ifdef DEBUG_UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
`ifdef DEBUG_UART_TX_PARITY_EN
    // Parity is latched in the same edge as entry to START; use the fresh value on entry.
    if (state_q == ST_DATA && state_d == ST_PARITY) begin
      tx_d = parity_q;
    end
`endif
  end

  assign o_tx      = tx_q;
  assign o_ready   = (state_q == ST_IDLE);
  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: a per-cycle line-waveform model plus a host-side sampler
// decoding frames at bit centres against an expected-word queue.
module tb_debug_uart_tx;

  localparam int W   = 8;
  localparam int CPB = 4;
`ifdef DEBUG_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB    = W + 2 + PAR;
  localparam int FRAME = NB * CPB;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         tx;
  logic         busy;
  logic         done;
  logic [2:0]   state_dbg;

  debug_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .i_reset_n (reset_n),
    .i_data    (data),
    .i_valid   (valid),
    .o_ready   (ready),
    .o_tx      (tx),
    .o_busy    (busy),
    .o_done    (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_fail = 0;
  int           n_accepted = 0;
  int           n_decoded = 0;
  logic [W-1:0] exp_q[$];
  logic         wave[$];
  logic         exp_done = 1'b0;
  logic         exp_tx;
  logic         idle;
  logic         dec_active = 1'b0;
  int           dec_cnt = 0;
  int           idx;
  logic [W-1:0] dec_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line level for each cycle of one frame, straight from the frame format.
  task automatic push_frame(input logic [W-1:0] d);
    logic b;
    for (int n = 0; n < NB; n++) begin
      if (n == 0)            b = 1'b0;
      else if (n <= W)       b = d[n-1];
      else if (n == NB - 1)  b = 1'b1;
      else                   b = 1'(($countones(d)) % 2);
      for (int c = 0; c < CPB; c++) wave.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_tx", tx, 1);
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      n_accepted -= exp_q.size();
      wave.delete();
      exp_q.delete();
      exp_done   = 1'b0;
      dec_active = 1'b0;
    end else begin
      idle   = (wave.size() == 0);
      exp_tx = idle ? 1'b1 : wave[0];
      check("tx", tx, exp_tx);
      check("busy", busy, !idle);
      check("ready", ready, idle);
      check("done", done, exp_done);
      if (idle) begin
        exp_done = 1'b0;
        if (valid) begin
          push_frame(data);
          exp_q.push_back(data);
          n_accepted++;
        end
      end else begin
        void'(wave.pop_front());
        exp_done = (wave.size() == 0);
      end

      // host-side sampler
      if (!dec_active && tx == 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
        dec_word   = '0;
      end
      if (dec_active) begin
        if (dec_cnt % CPB == CPB / 2) begin
          idx = dec_cnt / CPB;
          if (idx == 0) check("dec_start", tx, 0);
          else if (idx <= W) dec_word[idx-1] = tx;
`ifdef DEBUG_UART_TX_PARITY_EN
          else if (idx == W + 1) check("dec_parity", tx, $countones(dec_word) % 2);
`endif
          if (idx == NB - 1) begin
            check("dec_stop", tx, 1);
            check("dec_have_exp", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("dec_word", dec_word, exp_q.pop_front());
            n_decoded++;
            dec_active = 1'b0;
          end
        end
        dec_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input int budget, output int waited);
    waited = 0;
    while (!ready && waited < budget) begin
      step();
      waited++;
    end
    check("ready_timeout", ready, 1);
  endtask

  task automatic send_word(input logic [W-1:0] d);
    int w;
    wait_ready(FRAME * 2 + 4, w);
    data  = d;
    valid = 1'b1;
    step();
    valid = 1'b0;
    data  = W'($urandom);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] sweep[4];
  int cyc, busy_cnt, w, dec0;

  initial begin
    reset_n = 1'b1;
    valid   = 1'b0;
    data    = '0;
    #1 reset_n = 1'b0;
    repeat (3) step();
    check("reset_tx", tx, 1);
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_state_idle", state_dbg, 0);
    reset_n = 1'b1;
    step();

    // single frame: length and done position
    send_word(8'h33);
    cyc = 1;
    busy_cnt = 0;
    while (!done && cyc <= FRAME + 10) begin
      if (busy) busy_cnt++;
      step();
      cyc++;
    end
    check("frame_busy_cycles", busy_cnt, FRAME);
    check("done_cycle", cyc, FRAME + 1);
    step();
    check("done_one_cycle", done, 0);
    send_word(8'h07);

    // back-to-back sweep with valid held
    sweep = '{8'h00, 8'h11, 8'h22, 8'h33};
    wait_ready(FRAME * 2 + 4, w);
    dec0  = n_decoded;
    valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data = sweep[k];
      wait_ready(FRAME * 2 + 4, w);
      if (k > 0) begin
        check("b2b_gap", w, FRAME);
        check("b2b_done", done, 1);
        check("b2b_tx", tx, 1);
      end
      step();
      check("b2b_accepted", ready, 0);
    end
    valid = 1'b0;
    wait_ready(FRAME * 2 + 4, w);
    check("sweep_frames", n_decoded - dec0, 4);

    // valid while busy is dropped
    dec0 = n_decoded;
    send_word(8'h11);
    repeat (10) step();
    data  = 8'hFF;
    valid = 1'b1;
    step();
    valid = 1'b0;
    wait_ready(FRAME * 2 + 4, w);
    repeat (FRAME) step();
    check("ignore_frames", n_decoded - dec0, 1);
    check("ignore_idle", busy, 0);

    // reset during data bit 3 aborts the frame at once
    send_word(8'hA5);
    repeat (17) step();
    check("abort_pre_tx", tx, 0);
    reset_n = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_ready", ready, 1);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    dec0 = n_decoded;
    send_word(8'hA5);
    wait_ready(FRAME * 2 + 4, w);
    check("after_abort_frames", n_decoded - dec0, 1);

    // random valid/data traffic
    for (int i = 0; i < 1500; i++) begin
      valid = ($urandom_range(0, 3) != 0);
      data  = W'($urandom);
      step();
    end
    valid = 1'b0;
    wait_ready(FRAME * 2 + 4, w);
    repeat (4) step();
    check("scoreboard_empty", exp_q.size(), 0);
    check("frames_all_decoded", n_decoded, n_accepted);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
